// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit positions.
package cp0_regfile_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   localparam int STATUS_BEV   = 22;
   localparam int STATUS_IM_LO = 8;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IE    = 0;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_TI     = 30;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_EXC_LO = 2;

   // valid, ex, excode, bd, pc, badvaddr, eret, mtc0_we, addr, wdata
   localparam int WS_CP0_BUS_WD = 1 + 1 + 5 + 1 + 32 + 32 + 1 + 1 + 5 + 32;

   // Only address-error exceptions latch the faulting address.
   function automatic logic is_addr_exc(input logic [4:0] excode);
      return (excode == EXC_ADEL) || (excode == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI latches on a Compare match.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic        tick_q, tick_d;
   logic        ti_q, ti_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] count_inc;

   always_comb begin
      count_inc = count_q + 32'd1;
      tick_d    = ~tick_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      // A software Count write takes priority over the half-rate increment.
      if (count_we) begin
         count_d = wdata;
      end else if (tick_q) begin
         count_d = count_inc;
         if (count_inc == compare_q) ti_d = 1'b1;
      end
      if (compare_we) begin
         compare_d = wdata;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q    <= 1'b0;
         ti_q      <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
      end else begin
         tick_q    <= tick_d;
         ti_q      <= ti_d;
         count_q   <= count_d;
         compare_q <= compare_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception/interrupt controller driven from the WB stage.
// Timer (Count/Compare/TI) is built only when CP0_TIMER_INT_EN is defined.
module cp0_regfile
   import cp0_regfile_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ws_valid,
   input  logic        ws_ex,
   input  logic [4:0]  ws_excode,
   input  logic        ws_bd,
   input  logic [31:0] ws_pc,
   input  logic [31:0] ws_badvaddr,
   input  logic        ws_eret,
   input  logic        ws_mtc0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic [5:0]  ext_int,
   output logic [31:0] cp0_rdata,
   output logic        has_int,
   output logic        ex_flush,
   output logic        eret_flush,
   output logic [31:0] flush_pc
);

   logic ex, eret, mtc0;
   assign ex   = ws_valid & ws_ex;
   assign eret = ws_valid & ws_eret & ~ws_ex;
   assign mtc0 = ws_valid & ws_mtc0_we & ~ws_ex;

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [4:0]  excode_q, excode_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;

   logic [31:0] count, compare;
   logic        ti;

`ifdef CP0_TIMER_INT_EN
   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (mtc0 && (cp0_addr == CP0_COUNT)),
      .compare_we (mtc0 && (cp0_addr == CP0_COMPARE)),
      .wdata      (cp0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );
`else
   assign count   = '0;
   assign compare = '0;
   assign ti      = 1'b0;
`endif

   logic [7:0]  ip;
   logic [31:0] status_rd, cause_rd;

   assign ip        = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
   assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_rd  = {bd_q, ti, 14'b0, ip, 1'b0, excode_q, 2'b0};

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      ip_hw_d    = ext_int;
      excode_d   = excode_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;

      if (mtc0) begin
         case (cp0_addr)
            CP0_STATUS: begin
               im_d  = cp0_wdata[STATUS_IM_LO +: 8];
               exl_d = cp0_wdata[STATUS_EXL];
               ie_d  = cp0_wdata[STATUS_IE];
            end
            CP0_CAUSE: ip_sw_d = cp0_wdata[CAUSE_IP_LO +: 2];
            CP0_EPC:   epc_d   = cp0_wdata;
            default: ;
         endcase
      end

      if (eret) exl_d = 1'b0;

      // A nested exception (EXL already set) must not clobber the original return point.
      if (ex) begin
         if (!exl_q) begin
            epc_d = ws_bd ? (ws_pc - 32'd4) : ws_pc;
            bd_d  = ws_bd;
         end
         exl_d    = 1'b1;
         excode_d = ws_excode;
         if (is_addr_exc(ws_excode)) badvaddr_d = ws_badvaddr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
         excode_q   <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_sw_q    <= ip_sw_d;
         ip_hw_q    <= ip_hw_d;
         excode_q   <= excode_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_BADVADDR: cp0_rdata = badvaddr_q;
         CP0_COUNT:    cp0_rdata = count;
         CP0_COMPARE:  cp0_rdata = compare;
         CP0_STATUS:   cp0_rdata = status_rd;
         CP0_CAUSE:    cp0_rdata = cause_rd;
         CP0_EPC:      cp0_rdata = epc_q;
         default:      cp0_rdata = '0;
      endcase
   end

   assign has_int    = (|(ip & im_q)) & ie_q & ~exl_q;
   assign ex_flush   = ex & ~reset;
   assign eret_flush = eret & ~reset;
   assign flush_pc   = ex ? EX_ENTRY : epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expected values are queued as stimulus is driven, popped on sampling.
module tb_cp0_regfile;
   import cp0_regfile_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_valid, ws_ex, ws_bd, ws_eret, ws_mtc0_we;
   logic [4:0]  ws_excode, cp0_addr;
   logic [31:0] ws_pc, ws_badvaddr, cp0_wdata;
   logic [5:0]  ext_int;
   logic [31:0] cp0_rdata, flush_pc;
   logic        has_int, ex_flush, eret_flush;

   cp0_regfile dut (
      .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_ex(ws_ex), .ws_excode(ws_excode),
      .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret),
      .ws_mtc0_we(ws_mtc0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .ext_int(ext_int),
      .cp0_rdata(cp0_rdata), .has_int(has_int), .ex_flush(ex_flush), .eret_flush(eret_flush),
      .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs, e;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ws_valid = 0; ws_ex = 0; ws_excode = 0; ws_bd = 0; ws_pc = 0;
      ws_badvaddr = 0; ws_eret = 0; ws_mtc0_we = 0; cp0_wdata = 0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      idle();
      cp0_addr = a;
      #1;
      d = cp0_rdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      idle();
      cp0_addr = a; cp0_wdata = d; ws_valid = 1; ws_mtc0_we = 1;
      cyc();
      idle();
   endtask

   task automatic test_reset();
      reset = 1; idle(); ext_int = 0; cp0_addr = 0;
      repeat (2) cyc();
      reset = 0;
      exp_q.push_back(32'h0040_0000); rd(CP0_STATUS, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_status got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0); rd(CP0_CAUSE, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_cause got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0); rd(CP0_EPC, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_epc got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0); obs = {29'b0, has_int, ex_flush, eret_flush}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_flags got=%h want=%h", obs, e); end
   endtask

   task automatic test_exception();
      idle();
      ws_valid = 1; ws_ex = 1; ws_excode = EXC_ADEL; ws_pc = 32'hBFC0_0100; ws_bd = 1;
      ws_badvaddr = 32'h0000_0003;
      exp_q.push_back({30'b0, 1'b1, 1'b0}); exp_q.push_back(32'hBFC0_0380);
      #1;
      obs = {30'b0, ex_flush, eret_flush}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ex_flags got=%h want=%h", obs, e); end
      obs = flush_pc; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ex_flush_pc got=%h want=%h", obs, e); end
      cyc();
      exp_q.push_back(32'hBFC0_00FC); rd(CP0_EPC, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ex_epc got=%h want=%h", obs, e); end
      exp_q.push_back(32'h8000_0010); rd(CP0_CAUSE, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ex_cause got=%h want=%h", obs, e); end
      exp_q.push_back(32'h3); rd(CP0_BADVADDR, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ex_badvaddr got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0040_0002); rd(CP0_STATUS, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ex_status got=%h want=%h", obs, e); end
   endtask

   task automatic test_nested_eret();
      idle();
      ws_valid = 1; ws_ex = 1; ws_excode = EXC_OV; ws_pc = 32'hBFC0_0200; ws_badvaddr = 32'hDEAD;
      cyc();
      exp_q.push_back(32'hBFC0_00FC); rd(CP0_EPC, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL nest_epc got=%h want=%h", obs, e); end
      exp_q.push_back(32'h8000_0030); rd(CP0_CAUSE, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL nest_cause got=%h want=%h", obs, e); end
      idle();
      ws_valid = 1; ws_eret = 1;
      exp_q.push_back({30'b0, 1'b0, 1'b1}); exp_q.push_back(32'hBFC0_00FC);
      #1;
      obs = {30'b0, ex_flush, eret_flush}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL eret_flags got=%h want=%h", obs, e); end
      obs = flush_pc; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL eret_flush_pc got=%h want=%h", obs, e); end
      cyc();
      exp_q.push_back(32'h0040_0000); rd(CP0_STATUS, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL eret_status got=%h want=%h", obs, e); end
   endtask

   task automatic test_ex_mtc0_eret();
      idle();
      ws_valid = 1; ws_ex = 1; ws_excode = EXC_SYS; ws_pc = 32'h8000_0040; ws_eret = 1;
      ws_mtc0_we = 1; cp0_addr = CP0_EPC; cp0_wdata = 32'h1234;
      exp_q.push_back({30'b0, 1'b1, 1'b0});
      #1;
      obs = {30'b0, ex_flush, eret_flush}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL exer_flags got=%h want=%h", obs, e); end
      cyc();
      exp_q.push_back(32'h8000_0040); rd(CP0_EPC, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL exmtc0_epc got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0040_0002); rd(CP0_STATUS, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL exer_status got=%h want=%h", obs, e); end
      idle(); ws_valid = 1; ws_eret = 1;
      exp_q.push_back(32'h8000_0040);
      #1;
      obs = flush_pc; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL eret2_flush_pc got=%h want=%h", obs, e); end
      cyc(); idle();
   endtask

   task automatic test_sw_int();
      wr(CP0_STATUS, 32'h0000_0101);
      exp_q.push_back(32'h0040_0101); rd(CP0_STATUS, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_status got=%h want=%h", obs, e); end
      exp_q.push_back(0); obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_noint got=%h want=%h", obs, e); end
      wr(CP0_CAUSE, 32'h0000_0100);
      exp_q.push_back(1); obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_int got=%h want=%h", obs, e); end
      exp_q.push_back(32'h100); rd(CP0_CAUSE, obs); obs = obs & 32'hFF00; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_cause_ip got=%h want=%h", obs, e); end
      wr(CP0_STATUS, 32'h0000_0103);
      exp_q.push_back(0); obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_exl_mask got=%h want=%h", obs, e); end
      wr(CP0_STATUS, 32'h0000_0101);
      exp_q.push_back(1); obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_reenable got=%h want=%h", obs, e); end
      wr(CP0_CAUSE, 32'h0);
      exp_q.push_back(0); obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL sw_clear got=%h want=%h", obs, e); end
   endtask

   task automatic test_hw_int();
      wr(CP0_STATUS, 32'h0000_0401);
      ext_int = 6'b000001;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(32'h400); exp_q.push_back(0);
      #1;
      obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL hw_latency got=%h want=%h", obs, e); end
      cyc();
      obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL hw_int got=%h want=%h", obs, e); end
      rd(CP0_CAUSE, obs); obs = obs & 32'hFF00; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL hw_cause_ip got=%h want=%h", obs, e); end
      ext_int = 6'b0;
      cyc();
      obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL hw_drop got=%h want=%h", obs, e); end
      wr(CP0_BADVADDR, 32'h55);
      exp_q.push_back(32'h3); rd(CP0_BADVADDR, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL badvaddr_ro got=%h want=%h", obs, e); end
   endtask

   task automatic test_timer();
      logic found;
`ifdef CP0_TIMER_INT_EN
      wr(CP0_COUNT, 32'h0);
      wr(CP0_COMPARE, 32'd10);
      wr(CP0_STATUS, 32'h0000_8001);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         rd(CP0_CAUSE, obs);
         if (obs[CAUSE_TI]) found = 1;
         else cyc();
      end
      exp_q.push_back(1); obs = {31'b0, found}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL timer_ti_timeout got=%h want=%h", obs, e); end
      exp_q.push_back(32'd10); rd(CP0_COUNT, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL timer_count got=%h want=%h", obs, e); end
      exp_q.push_back(1); obs = {31'b0, has_int}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL timer_has_int got=%h want=%h", obs, e); end
      wr(CP0_COMPARE, 32'd100);
      exp_q.push_back(0); rd(CP0_CAUSE, obs); obs = {31'b0, obs[CAUSE_TI]}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL timer_ti_clear got=%h want=%h", obs, e); end
`else
      wr(CP0_COUNT, 32'h77);
      wr(CP0_COMPARE, 32'h5);
      exp_q.push_back(0); rd(CP0_COUNT, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL notimer_count got=%h want=%h", obs, e); end
      exp_q.push_back(0); rd(CP0_COMPARE, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL notimer_compare got=%h want=%h", obs, e); end
      wr(CP0_STATUS, 32'h0000_8001);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (has_int) found = 1;
      end
      exp_q.push_back(0); obs = {31'b0, found}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL notimer_int got=%h want=%h", obs, e); end
`endif
      wr(CP0_STATUS, 32'h0);
   endtask

   task automatic test_reset_midflight();
      idle();
      ws_valid = 1; ws_ex = 1; ws_excode = EXC_ADES; ws_pc = 32'h8000_1000; ws_badvaddr = 32'h77;
      reset = 1;
      exp_q.push_back(0);
      #1;
      obs = {31'b0, ex_flush}; e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_flush got=%h want=%h", obs, e); end
      cyc();
      reset = 0; idle();
      exp_q.push_back(32'h0040_0000); rd(CP0_STATUS, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_status got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0); rd(CP0_EPC, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_epc got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0); rd(CP0_BADVADDR, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_badvaddr got=%h want=%h", obs, e); end
      exp_q.push_back(32'h0); rd(CP0_CAUSE, obs); e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_cause got=%h want=%h", obs, e); end
   endtask

   initial begin
      test_reset();
      test_exception();
      test_nested_eret();
      test_ex_mtc0_eret();
      test_sw_int();
      test_hw_int();
      test_timer();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
